// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and a future receiver.
//   uart_state_e        - transmitter FSM state encoding
//   PARITY_NONE/EVEN/ODD - values of the PARITY parameter
//   parity_bit()        - maps the XOR of the data bits to the line parity bit
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    // Even parity sends the XOR of the data bits; odd parity sends its inverse.
    function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
//   CLK     in   system clock, rising edge
//   RST     in   synchronous active-low reset
//   BCLK    in   one-cycle baud tick per bit period
//   empty   in   transmit FIFO empty
//   rd_data in   FIFO read data, valid the cycle after rd_en
//   rd_en   out  FIFO read strobe, one cycle per byte
//   TX      out  serial line, registered, idles high
//   busy    out  high whenever the FSM is not idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY     = PARITY_NONE,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BCLK,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  TX,
    output logic                  busy
);

    localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + STOP_BITS + 1);
    localparam bit          HAS_PARITY = (PARITY != PARITY_NONE);

    uart_state_e           r_state;
    logic                  r_tx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par;
    logic                  r_busy;

    uart_state_e           w_state_nxt;
    logic                  w_tx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_par_nxt;

    // The strobe must be seen by the FIFO in the same IDLE cycle that decides
    // to fetch, so it is decoded from the state register; gated by reset so a
    // FIFO with data never pops while the transmitter is held in reset.
    assign rd_en = RST && (r_state == ST_IDLE) && !empty;
    assign TX    = r_tx;
    assign busy  = r_busy;

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and datapath update; TX only ever changes on a BCLK cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;

        unique case (r_state)
            ST_IDLE: begin
                if (!empty) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            // rd_data is valid during FETCH, so the byte and its parity are
            // latched as LOAD is entered; later changes on the FIFO side
            // cannot disturb the frame.
            ST_FETCH: begin
                w_state_nxt = ST_LOAD;
                w_shift_nxt = rd_data;
                w_cnt_nxt   = '0;
                w_par_nxt   = parity_bit(^rd_data, PARITY);
            end

            ST_LOAD: begin
                if (BCLK) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (BCLK) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_DATA;
                end
            end

            // r_cnt counts data bits already placed on the line.
            ST_DATA: begin
                if (BCLK) begin
                    if (r_cnt == CNT_W'(DATA_WIDTH)) begin
                        w_cnt_nxt = CNT_W'(1);
                        if (HAS_PARITY) begin
                            w_tx_nxt    = r_par;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (BCLK) begin
                    w_tx_nxt    = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_STOP;
                end
            end

            // r_cnt counts stop bits already started. The FSM leaves as the
            // last stop bit begins, so IDLE/FETCH/LOAD run during that bit and
            // the next start bit lands on the very next tick.
            ST_STOP: begin
                if (r_cnt >= CNT_W'(STOP_BITS)) begin
                    w_state_nxt = ST_IDLE;
                end else if (BCLK) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if ((r_cnt + CNT_W'(1)) == CNT_W'(STOP_BITS)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (8N1, 8E2, 8O1) fed from FIFO models, with a
// bit-level scoreboard that expects each queued byte's frame on TX.
module tb_uart_tx;

    localparam int N_DUT = 3;
    localparam int unsigned PAR_CFG  [N_DUT] = '{0, 1, 2};
    localparam int unsigned STOP_CFG [N_DUT] = '{1, 2, 1};

    typedef struct packed {
        logic [7:0] data;
        logic       par_even;   // XOR of the data bits, derived by hand
    } vec_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             BCLK;
    logic [N_DUT-1:0] empty;
    logic [N_DUT-1:0] rd_en;
    logic [N_DUT-1:0] tx;
    logic [N_DUT-1:0] busy;
    logic [7:0]       rd_data [N_DUT] = '{default: 8'h00};

    // FIFO models: main process owns wr_ptr/mem, the read process owns rd_ptr.
    logic [7:0] mem     [N_DUT][64];
    logic [5:0] wr_ptr  [N_DUT];
    logic [5:0] rd_ptr  [N_DUT] = '{default: 6'd0};
    int         rd_pulses [N_DUT] = '{default: 0};
    int         exp_pulses [N_DUT];

    // Scoreboard and line monitor state.
    logic exp_q0 [$];
    logic exp_q1 [$];
    logic exp_q2 [$];
    int   rem        [N_DUT];
    int   seen       [N_DUT];
    int   last_start [N_DUT];
    int   gap        [N_DUT];
    int   ticks;
    bit   tick_en;
    bit   idle_watch;
    int   bclk_per;

    int total = 0;
    int bad   = 0;

    uart_tx #(.DATA_WIDTH(8), .PARITY(PAR_CFG[0]), .STOP_BITS(STOP_CFG[0])) u_dut_n1 (
        .CLK(CLK), .RST(RST), .BCLK(BCLK), .empty(empty[0]), .rd_data(rd_data[0]),
        .rd_en(rd_en[0]), .TX(tx[0]), .busy(busy[0]));
    uart_tx #(.DATA_WIDTH(8), .PARITY(PAR_CFG[1]), .STOP_BITS(STOP_CFG[1])) u_dut_e2 (
        .CLK(CLK), .RST(RST), .BCLK(BCLK), .empty(empty[1]), .rd_data(rd_data[1]),
        .rd_en(rd_en[1]), .TX(tx[1]), .busy(busy[1]));
    uart_tx #(.DATA_WIDTH(8), .PARITY(PAR_CFG[2]), .STOP_BITS(STOP_CFG[2])) u_dut_o1 (
        .CLK(CLK), .RST(RST), .BCLK(BCLK), .empty(empty[2]), .rd_data(rd_data[2]),
        .rd_en(rd_en[2]), .TX(tx[2]), .busy(busy[2]));

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < N_DUT; i++) empty[i] = (wr_ptr[i] == rd_ptr[i]);
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (rd_en[i]) begin
                rd_data[i]   <= mem[i][rd_ptr[i]];
                rd_ptr[i]    <= rd_ptr[i] + 6'd1;
                rd_pulses[i] <= rd_pulses[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int frame_len(input int i);
        return 1 + 8 + ((PAR_CFG[i] != 0) ? 1 : 0) + int'(STOP_CFG[i]);
    endfunction

    function automatic int exp_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic exp_pop(input int i);
        case (i)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic exp_push(input int i, input logic b);
        case (i)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endtask

    // Queue a byte in FIFO i and the frame the line should carry for it.
    task automatic push_byte(input int i, input logic [7:0] d, input logic pe);
        mem[i][wr_ptr[i]] = d;
        wr_ptr[i] = wr_ptr[i] + 6'd1;
        exp_pulses[i]++;
        exp_push(i, 1'b0);
        for (int b = 0; b < 8; b++) exp_push(i, d[b]);
        if (PAR_CFG[i] == 1) exp_push(i, pe);
        else if (PAR_CFG[i] == 2) exp_push(i, ~pe);
        for (int s = 0; s < int'(STOP_CFG[i]); s++) exp_push(i, 1'b1);
    endtask

    // Called one cycle after each tick: compare every line bit against the scoreboard.
    task automatic sample_tick();
        logic e;
        ticks++;
        if (idle_watch) begin
            check("idle tx", 32'(tx), 32'd7);
            check("idle busy", 32'(busy), 32'd0);
            check("idle rd_en", 32'(rd_en), 32'd0);
        end
        for (int i = 0; i < N_DUT; i++) begin
            if (rem[i] > 0 || tx[i] == 1'b0) begin
                if (rem[i] == 0) begin
                    rem[i] = frame_len(i);
                    if (last_start[i] >= 0) gap[i] = ticks - last_start[i];
                    last_start[i] = ticks;
                end
                check($sformatf("dut%0d bit expected", i), 32'(exp_size(i) > 0), 32'd1);
                if (exp_size(i) > 0) begin
                    e = exp_pop(i);
                    check($sformatf("dut%0d tx bit %0d", i, frame_len(i) - rem[i]),
                          32'(tx[i]), 32'(e));
                end
                rem[i]--;
                seen[i]++;
            end
        end
    endtask

    // Baud tick generator; BCLK is high for one cycle every bclk_per cycles.
    initial begin
        BCLK = 1'b0;
        forever begin
            @(negedge CLK);
            BCLK = tick_en;
            @(negedge CLK);
            if (BCLK) sample_tick();
            BCLK = 1'b0;
            repeat (bclk_per - 2) @(negedge CLK);
        end
    end

    // The FIFO must never be strobed while it reports empty.
    always @(negedge CLK) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (rd_en[i]) check($sformatf("dut%0d rd_en while empty", i), 32'(empty[i]), 32'd0);
        end
    end

    task automatic wait_drain(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge CLK);
            n++;
            done = (exp_size(0) + exp_size(1) + exp_size(2) == 0) && (busy == '0);
        end
        check({name, " drained"}, 32'(done), 32'd1);
        check({name, " idle tx"}, 32'(tx), 32'd7);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("%s dut%0d rd_en pulses", name, i), 32'(rd_pulses[i]), 32'(exp_pulses[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   target;
        int   n;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'hA5, 1'b0};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h7F, 1'b1};
        vecs[7] = '{8'hC4, 1'b1};
        vecs[8] = '{8'h96, 1'b0};
        vecs[9] = '{8'h2A, 1'b1};

        RST        = 1'b0;
        tick_en    = 1'b0;
        idle_watch = 1'b0;
        bclk_per   = 6;
        ticks      = 0;
        for (int i = 0; i < N_DUT; i++) begin
            wr_ptr[i]     = 6'd0;
            exp_pulses[i] = 0;
            rem[i]        = 0;
            seen[i]       = 0;
            last_start[i] = -1;
            gap[i]        = 0;
        end

        // Reset state, with a byte already waiting in FIFO 0.
        repeat (3) @(negedge CLK);
        push_byte(0, 8'hC4, 1'b1);
        repeat (2) @(negedge CLK);
        check("reset tx", 32'(tx), 32'd7);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        RST     = 1'b1;
        tick_en = 1'b1;
        wait_drain("post-reset byte");

        // Nothing queued: ticks must leave the line idle.
        idle_watch = 1'b1;
        target = ticks + 100;
        n = 0;
        while (ticks < target && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        idle_watch = 1'b0;
        check("idle window ticks", 32'(ticks >= target), 32'd1);

        // One frame per vector on all three configurations.
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N_DUT; i++) push_byte(i, vecs[k].data, vecs[k].par_even);
            wait_drain($sformatf("vec%0d", k));
        end

        // Two queued bytes at the fastest tick rate: frames must abut.
        bclk_per = 4;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < N_DUT; i++) begin
            last_start[i] = -1;
            gap[i]        = 0;
            push_byte(i, 8'h00, 1'b0);
            push_byte(i, 8'hFF, 1'b0);
        end
        wait_drain("back-to-back");
        for (int i = 0; i < N_DUT; i++)
            check($sformatf("dut%0d start-to-start ticks", i), 32'(gap[i]), 32'(frame_len(i)));

        // Reset while data bit 3 of 0x0F is on the line, then a clean frame.
        bclk_per = 6;
        repeat (8) @(negedge CLK);
        target = seen[0] + 5;
        push_byte(0, 8'h0F, 1'b0);
        n = 0;
        while (seen[0] < target && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("reached data bit 3", 32'(seen[0] >= target), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        check("abort tx", 32'(tx), 32'd7);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rd_en", 32'(rd_en), 32'd0);
        RST = 1'b1;
        exp_q0.delete();
        rem[0] = 0;
        repeat (30) @(negedge CLK);
        check("after abort tx", 32'(tx[0]), 32'd1);
        check("after abort rd_en pulses", 32'(rd_pulses[0]), 32'(exp_pulses[0]));
        push_byte(0, 8'h3C, 1'b0);
        wait_drain("after abort 0x3C");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame.
REQ-002 SHALL have parameter PARITY, default 0, where 0 means none, 1 means even and 2 means odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, with legal values 1 and 2.
REQ-004 SHALL have port CLK, input, 1 bit: the 50 MHz system clock; all logic runs on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port BCLK, input, 1 bit: baud tick, a one-CLK-cycle pulse per bit period from the baud-rate generator.
REQ-007 SHALL have port empty, input, 1 bit: the transmit FIFO is empty.
REQ-008 SHALL have port rd_data, input, DATA_WIDTH bits: FIFO read data, valid on the CLK cycle after rd_en.
REQ-009 SHALL have port rd_en, output, 1 bit: FIFO read strobe, one cycle per byte.
REQ-010 SHALL have port TX, output, 1 bit: serial line, registered, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-013 In IDLE with empty=0, SHALL assert rd_en for exactly one cycle and move to FETCH; with empty=1, SHALL stay in IDLE with rd_en=0.
REQ-014 FETCH SHALL last one cycle, rd_en=0, with the next state LOAD.
REQ-015 LOAD SHALL capture rd_data into the shift register, clear the bit counter, then wait for BCLK; on BCLK it SHALL set TX<=0 and move to START.
REQ-016 In START, on BCLK it SHALL set TX<=shift[0] and move to DATA.
REQ-017 In DATA, on each BCLK it SHALL shift right (LSB first) and increment the counter; after DATA_WIDTH bits have been driven, it SHALL set TX<=parity bit and move to PARITY if PARITY!=0, else set TX<=1 and move to STOP.
REQ-018 The parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity, computed from the byte captured in LOAD.
REQ-019 In PARITY, on BCLK it SHALL set TX<=1 and move to STOP.
REQ-020 STOP SHALL hold TX=1 for STOP_BITS BCLK ticks, then go to IDLE on the final tick.
REQ-021 The frame SHALL last exactly 1+DATA_WIDTH+(PARITY!=0)+STOP_BITS bit periods, each bit period running from one BCLK tick to the next.
REQ-022 Back-to-back frames SHALL occur with no idle bit time between the stop bit and the next start bit, provided BCLK ticks are at least 4 CLK cycles apart.
REQ-023 BCLK ticks in IDLE and FETCH SHALL be ignored; BCLK has no effect in IDLE.
REQ-024 Changes to empty after the rd_en cycle SHALL not affect the frame in progress.
REQ-025 rd_en SHALL never be asserted when empty=1, nor in any state other than IDLE, so the FIFO never underflows.
REQ-026 TX SHALL change only on CLK edges where BCLK=1, except when reset is applied.

Reset
REQ-027 RST=0 sampled on a rising CLK edge SHALL force state=IDLE, TX=1, rd_en=0, busy=0, and clear the counter and shift register.
REQ-028 Reset during a frame SHALL abort it at the next CLK edge: TX returns high and the byte is lost; no further rd_en occurs until RST=1 and the FSM is in IDLE.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state encoding and the parity constants PARITY_NONE=0, PARITY_EVEN=1 and PARITY_ODD=2, shared with a future uart_rx.
REQ-030 The block SHALL be a single module with no sub-modules; parity SHALL be a reduction XOR inline.

Verification
REQ-031 With PARITY=0 and STOP_BITS=1, pushing 0x55 SHALL give one rd_en pulse and TX per tick of 0,1,0,1,0,1,0,1,0,1, then idle high with busy low.
REQ-032 With PARITY=1, pushing 0xA5 SHALL give TX of 0,1,0,1,0,0,1,0,1,0(parity),1; with PARITY=2, the parity bit SHALL be 1.
REQ-033 With STOP_BITS=2 and two bytes 0x00 and 0xFF queued, SHALL give exactly two stop ticks high, then the start bit of 0xFF on the very next tick, with two rd_en pulses in total.
REQ-034 With empty held 1 and BCLK toggling for 100 ticks, SHALL give TX=1, rd_en=0 and busy=0 throughout.
REQ-035 RST=0 asserted for 1 cycle at data bit 3 of 0x0F SHALL give TX=1 and busy=0 the next cycle; a following queued 0x3C SHALL then transmit a clean full frame.
